serv_alu_seq: RTL

- Bit-serial sequencer for the serial ALU.
- Accepts one ALU/branch operation at a time over a valid/ready handshake.
- Generates the ALU enable, init and shift-amount-load strobes plus a bit counter for the operand shift registers. Reports the compare result at the end.
- Sits between decode/control and the serial ALU; one instance per core.

---
 rtl/serv_alu_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/serv_alu_seq.sv
// ---------------------------------------------------------------------------
// serv_alu_seq
//
// Bit-serial sequencer for the serial ALU. It accepts one ALU or branch
// operation at a time over a valid/ready handshake. It then generates the
// ALU strobes (enable, init, shift-amount load) and a bit counter for the
// operand shift registers. For branch operations it also captures the
// compare result on the last bit.
//
// Phases per operation:
//   IDLE  -> waiting for a request
//   SHAMT -> SHAMT_W cycles of o_shamt_en (right shifts only)
//   RUN   -> WIDTH cycles of o_en, with o_cnt counting 0..WIDTH-1
//   DONE  -> a single cycle of o_done
//
// Optional build macro:
//   SERV_ALU_SEQ_STALL_EN - adds input i_stall. While i_stall is high in
//   SHAMT or RUN, the phase counters and the state hold and the ALU strobes
//   are masked. The operation then resumes on the bit where it stopped.
//
// Ports:
//   clk            clock
//   i_rst          synchronous active-high reset
//   i_req_valid    operation request
//   o_req_ready    sequencer can accept a request (IDLE and no flush)
//   i_req_op       ALU op code
//   i_req_funct3   branch condition
//   i_req_branch   request is a compare, not a writeback op
//   i_flush        abort current operation
//   i_stall        (SERV_ALU_SEQ_STALL_EN only) pause SHAMT/RUN
//   i_cmp          compare output from the ALU
//   o_op           latched op code to the ALU
//   o_funct3       latched funct3 to the ALU
//   o_shamt_en     ALU shift-amount register load enable
//   o_en           ALU enable
//   o_init         ALU init (shifter load / eq accumulate)
//   o_cnt          current bit index in RUN, 0 elsewhere
//   o_cnt_last     o_cnt == WIDTH-1 while in RUN
//   o_rd_we        serial rd bit valid for writeback
//   o_done         one-cycle completion pulse
//   o_cmp_result   latched compare result
// ---------------------------------------------------------------------------
module serv_alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [2:0]               i_req_op,
    input  logic [2:0]               i_req_funct3,
    input  logic                     i_req_branch,
    input  logic                     i_flush,
`ifdef SERV_ALU_SEQ_STALL_EN
    input  logic                     i_stall,
`endif
    input  logic                     i_cmp,
    output logic [2:0]               o_op,
    output logic [2:0]               o_funct3,
    output logic                     o_shamt_en,
    output logic                     o_en,
    output logic                     o_init,
    output logic [$clog2(WIDTH)-1:0] o_cnt,
    output logic                     o_cnt_last,
    output logic                     o_rd_we,
    output logic                     o_done,
    output logic                     o_cmp_result
);

    localparam int CNT_W = $clog2(WIDTH);

    // Right-shift op code as seen on the ALU op input. It is the only op
    // that needs the serial shift-amount load before RUN.
    localparam logic [2:0] ALU_OP_SR = 3'b101;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       SHAMT_LAST = 3'(SHAMT_W - 1);

    // Strobe bank bit positions
    localparam int ST_SHAMT = 0;
    localparam int ST_EN    = 1;
    localparam int ST_INIT  = 2;
    localparam int ST_RDWE  = 3;
    localparam int ST_DONE  = 4;
    localparam int ST_N     = 5;

    // Strobes that a stall masks. o_done is never active in SHAMT/RUN,
    // so it needs no mask.
    localparam logic [ST_N-1:0] STALL_MASK = 5'b01111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHAMT = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        shamt_cnt_reg, shamt_cnt_next;
    logic [2:0]        op_reg, op_next;
    logic [2:0]        funct3_reg, funct3_next;
    logic              branch_reg, branch_next;
    logic              cmp_reg, cmp_next;
    logic [ST_N-1:0]   strobe_reg, strobe_next;
    logic [ST_N-1:0]   strobe_out;

    logic              stall_gate;
    logic              req_ready;
    logic              accept;
    logic              busy_phase;

    assign busy_phase = (state_reg == S_SHAMT) || (state_reg == S_RUN);

`ifdef SERV_ALU_SEQ_STALL_EN
    assign stall_gate = i_stall && busy_phase;
`else
    assign stall_gate = 1'b0;
`endif

    assign req_ready = (state_reg == S_IDLE) && !i_flush;
    assign accept    = i_req_valid && req_ready;

    // ------------------------------------------------------------------
    // Next-state, counters and latched request fields
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shamt_cnt_next = shamt_cnt_reg;
        op_next        = op_reg;
        funct3_next    = funct3_reg;
        branch_next    = branch_reg;
        cmp_next       = cmp_reg;

        if (i_flush) begin
            // Abort: no o_done, compare result untouched
            state_next     = S_IDLE;
            cnt_next       = '0;
            shamt_cnt_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_next        = i_req_op;
                        funct3_next    = i_req_funct3;
                        branch_next    = i_req_branch;
                        cnt_next       = '0;
                        shamt_cnt_next = '0;
                        state_next     = (i_req_op == ALU_OP_SR) ? S_SHAMT : S_RUN;
                    end
                end
                S_SHAMT: begin
                    if (!stall_gate) begin
                        if (shamt_cnt_reg == SHAMT_LAST) begin
                            shamt_cnt_next = '0;
                            state_next     = S_RUN;
                        end else begin
                            shamt_cnt_next = shamt_cnt_reg + 3'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall_gate) begin
                        if (cnt_reg == CNT_LAST) begin
                            // The ALU presents the final compare bit alongside the last operand bit
                            if (branch_reg) begin
                                cmp_next = i_cmp;
                            end
                            cnt_next   = '0;
                            state_next = S_DONE;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobes are derived from the next state and counter so that the
    // registered value lines up with the phase it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        strobe_next           = '0;
        strobe_next[ST_SHAMT] = (state_next == S_SHAMT);
        strobe_next[ST_EN]    = (state_next == S_RUN);
        strobe_next[ST_INIT]  = (state_next == S_RUN) && (branch_next || (cnt_next == '0));
        strobe_next[ST_RDWE]  = (state_next == S_RUN) && !branch_next;
        strobe_next[ST_DONE]  = (state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            shamt_cnt_reg <= '0;
            op_reg        <= '0;
            funct3_reg    <= '0;
            branch_reg    <= 1'b0;
            cmp_reg       <= 1'b0;
            strobe_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shamt_cnt_reg <= shamt_cnt_next;
            op_reg        <= op_next;
            funct3_reg    <= funct3_next;
            branch_reg    <= branch_next;
            cmp_reg       <= cmp_next;
            strobe_reg    <= strobe_next;
        end
    end

    // A stalled cycle must not advance the ALU. The registered strobe
    // stays set while the counters hold, so the stall masks it for that
    // cycle only and the same bit is replayed on release.
    generate
        for (genvar gi = 0; gi < ST_N; gi++) begin : g_strobe
            if (STALL_MASK[gi]) begin : g_masked
                assign strobe_out[gi] = strobe_reg[gi] && !stall_gate;
            end else begin : g_plain
                assign strobe_out[gi] = strobe_reg[gi];
            end
        end
    endgenerate

    assign o_req_ready  = req_ready;
    assign o_op         = op_reg;
    assign o_funct3     = funct3_reg;
    assign o_shamt_en   = strobe_out[ST_SHAMT];
    assign o_en         = strobe_out[ST_EN];
    assign o_init       = strobe_out[ST_INIT];
    assign o_rd_we      = strobe_out[ST_RDWE];
    assign o_done       = strobe_out[ST_DONE];
    assign o_cnt        = cnt_reg;
    assign o_cnt_last   = (state_reg == S_RUN) && (cnt_reg == CNT_LAST);
    assign o_cmp_result = cmp_reg;

endmodule
